// File: rtl/VX_gpu_pkg.sv
// Shared GPU types: commit beat layout, sizing constants and small helpers
// used by the commit arbiter and its skid buffer.
package VX_gpu_pkg;

  localparam int NUM_THREADS = 4;
  localparam int UUID_W      = 16;
  localparam int NW_W        = 2;
  localparam int XLEN        = 32;
  localparam int NUM_REGS_W  = 5;
  localparam int PID_W       = 1;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COMMIT_NUM_INPUTS = 4;
  localparam int COMMIT_SEL_W      = log2up(COMMIT_NUM_INPUTS);

  typedef struct packed {
    logic [UUID_W-1:0]                 uuid;
    logic [NW_W-1:0]                   wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [XLEN-1:0]                   PC;
    logic                              wb;
    logic [NUM_REGS_W-1:0]             rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic [PID_W-1:0]                  pid;
    logic                              sop;
    logic                              eop;
  } commit_data_t;

  localparam int COMMIT_DATAW = $bits(commit_data_t);

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vx_commit_skid.sv
// Two-entry skid buffer. Upstream ready comes only from occupancy, so it never
// depends combinationally on downstream ready.
module vx_commit_skid #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  logic [DATAW-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: round-robin over execute-unit commit sources with packet
// locking, a skid-buffered output, commit counters and a sticky protocol flag.
module vx_commit_arb
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LANES  = NUM_THREADS,
  parameter int SEL_W      = log2up(NUM_INPUTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic         [NUM_INPUTS-1:0] in_valid,
  input  commit_data_t [NUM_INPUTS-1:0] in_data,
  output logic         [NUM_INPUTS-1:0] in_ready,
  output logic                          out_valid,
  output commit_data_t                  out_data,
  input  logic                          out_ready,
  output logic         [SEL_W-1:0]      out_sel,
  output logic         [63:0]           instr_count,
  output logic         [63:0]           thread_count,
  output logic                          proto_err
);

  // Handshake: a beat moves on any port exactly when valid && ready at a rising
  // edge; valid, once raised, is expected to hold with stable data until taken.

  arb_state_t       state;
  logic [SEL_W-1:0] lock_src;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             buf_ready;
  logic             fire;
  commit_data_t     beat;
  logic             out_fire;
  logic [SEL_W+COMMIT_DATAW-1:0] skid_out;

  function automatic logic [SEL_W-1:0] wrap_idx(input int v);
    return SEL_W'(v % NUM_INPUTS);
  endfunction

  function automatic logic [63:0] lane_count(input logic [NUM_THREADS-1:0] m);
    logic [63:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n = n + 64'(m[i]);
    end
    return n;
  endfunction

  // Scan downwards so the source closest to rr_ptr is the last (winning) hit.
  always_comb begin
    grant       = rr_ptr;
    grant_valid = 1'b0;
    if (state == ARB_LOCKED) begin
      grant       = lock_src;
      grant_valid = in_valid[lock_src];
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (in_valid[wrap_idx(int'(rr_ptr) + k)]) begin
          grant       = wrap_idx(int'(rr_ptr) + k);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_valid && buf_ready) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign fire     = grant_valid && buf_ready;
  assign beat     = in_data[grant];
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_OPEN;
      lock_src  <= '0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else if (fire) begin
      rr_ptr <= wrap_idx(int'(grant) + 1);
      if (state == ARB_LOCKED) begin
        if (beat.sop) proto_err <= 1'b1;
        if (beat.eop) state <= ARB_OPEN;
      end else begin
        if (!beat.sop) proto_err <= 1'b1;
        if (beat.sop && !beat.eop) begin
          state    <= ARB_LOCKED;
          lock_src <= grant;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count  <= '0;
      thread_count <= '0;
    end else if (out_fire) begin
      thread_count <= thread_count + lane_count(out_data.tmask);
      if (out_data.eop) instr_count <= instr_count + 64'd1;
    end
  end

  vx_commit_skid #(
    .DATAW (SEL_W + COMMIT_DATAW)
  ) skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fire),
    .in_data   ({grant, beat}),
    .in_ready  (buf_ready),
    .out_valid (out_valid),
    .out_data  (skid_out),
    .out_ready (out_ready)
  );

  assign {out_sel, out_data} = skid_out;

endmodule

// File: doc/vx_commit_arb.md
VX_COMMIT_ARB -- requirements
Module: vx_commit_arb

Interface
- REQ-001: NUM_INPUTS, default 4, number of upstream execute-unit commit sources (≥1).
- REQ-002: NUM_LANES, default `NUM_THREADS, lanes per commit beat.
- REQ-003: Input and output beats SHALL be of type commit_data_t, taken from the shared package: uuid, wid, tmask[NUM_LANES], PC, wb, rd, data, pid, sop, eop.
- REQ-004: clk  in  1  single clock; all logic rising-edge.
- REQ-005: reset  in  1  synchronous, active-high.
- REQ-006: in_valid  in  NUM_INPUTS  per-source beat valid.
- REQ-007: in_data  in  NUM_INPUTS x commit_data_t  per-source beat.
- REQ-008: in_ready  out  NUM_INPUTS  per-source accept.
- REQ-009: out_valid  out  1  beat valid to writeback.
- REQ-010: out_data  out  commit_data_t  granted beat.
- REQ-011: out_ready  in  1  writeback accept.
- REQ-012: out_sel  out  LOG2UP(NUM_INPUTS)  source index of out_data.
- REQ-013: instr_count  out  64  committed instruction count.
- REQ-014: thread_count  out  64  committed active-lane count.
- REQ-015: proto_err  out  1  sticky packet-protocol error.

Function
- REQ-016: Transfer SHALL occur on a port when valid and ready are both 1 at a rising edge; valid-ready semantics on all ports; in_ready SHALL NOT depend combinationally on out_ready.
- REQ-017: Unlocked arbitration SHALL be round-robin over asserted in_valid, starting from pointer rr_ptr (reset 0); after a transfer from source i, rr_ptr SHALL become (i+1) mod NUM_INPUTS.
- REQ-018: An accepted beat with sop=1, eop=0 SHALL lock the grant to that source; only that source's in_ready may assert until its beat with eop=1 is accepted, which SHALL release the lock the next cycle.
- REQ-019: A beat with sop=1, eop=1 SHALL be a single-beat packet and SHALL NOT lock.
- REQ-020: in_ready[i] SHALL be 1 only for the granted source and only when the output buffer has a free entry; at most one in_ready bit SHALL be set per cycle.
- REQ-021: The output path SHALL be a 2-entry skid buffer: latency 1 cycle from input transfer to out_valid; full throughput (1 beat/cycle) while out_ready=1; beats SHALL leave in acceptance order.
- REQ-022: out_sel SHALL be stored alongside each buffered beat.
- REQ-023: On each output transfer, thread_count SHALL add popcount(out_data.tmask); if out_data.eop=1, instr_count SHALL add 1; both wrap modulo 2^64.
- REQ-024: While locked, an accepted beat from the locked source with sop=1, or an accepted unlocked beat with sop=0, SHALL set proto_err; the beat is still forwarded.
- REQ-025: Buffer full and empty at once not possible; simultaneous enqueue and dequeue on a full buffer SHALL NOT be allowed (in_ready=0 when full).

Reset
- REQ-026: On reset: out_valid=0, in_ready=0, buffer empty, rr_ptr=0, lock cleared, out_sel=0, instr_count=0, thread_count=0, proto_err=0.
- REQ-027: Reset mid-packet SHALL discard buffered beats and the lock; no partial count update.

Structure
- REQ-028: commit_data_t, COMMIT_DATAW and the source-index width SHALL live in VX_gpu_pkg.
- REQ-029: The skid buffer SHALL be the sub-module vx_commit_skid (DATAW param, valid/ready both sides).

Verification
- REQ-030: After reset, sources 0 and 2 each offer one sop=eop=1 beat continuously, out_ready=1 -> outputs alternate out_sel 0,2,0,2, one beat/cycle after 1-cycle latency.
- REQ-031: Source 1 sends a 3-beat packet (sop,-,eop) while source 0 is valid -> three source-1 beats contiguous on out; source 0 is granted the cycle after the eop is accepted.
- REQ-032: out_ready held 0 for 5 cycles with all sources valid -> exactly 2 beats accepted, no loss or duplication on release.
- REQ-033: 4 single-beat packets with tmask 0xF, 0x1, 0x3, 0x0 (NUM_LANES=4) -> instr_count=4, thread_count=7.
- REQ-034: Locked source sends a second sop before eop -> proto_err=1 and stays 1 until reset.
- REQ-035: Reset asserted with 2 beats buffered and lock held -> out_valid=0 next cycle, counters 0, rr_ptr 0.
